multicycle_ctrl: RTL

//  Multi-cycle control FSM that sequences the shared PC/IR/regfile/ALU datapath.
//  Per instruction: fetch via imem handshake, decode, execute, then write back or branch.

---
 rtl/multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle datapath that shares one PC, IR, register file
// and ALU. Each instruction walks through FETCH -> DECODE -> EXEC and finishes
// in either WB (register-writing and illegal instructions) or BRANCH (BEQ/BNE).
// With a zero-wait instruction memory, every instruction takes 4 cycles.
//
// Parameters
//   CNT_W    width of the retired-instruction counter (wraps modulo 2^CNT_W)
//   TIMEOUT  FETCH wait cycles without imem_ready_i before fetch_err_o is set;
//            0 disables the timeout
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_i         in   synchronous reset, active-high; aborts any instruction
//   halt_i        in   holds the FSM in FETCH without issuing a request
//   imem_ready_i  in   instruction memory data valid this cycle
//   instr_op_i    in   opcode field of IR, sampled in DECODE
//   zero_i        in   ALU zero flag, sampled in BRANCH
//   imem_req_o    out  instruction fetch request
//   IR_write_o    out  load IR from imem (1-cycle pulse)
//   PC_write_o    out  update PC (1-cycle pulse, WB or BRANCH)
//   PC_src_o      out  0: PC+4, 1: branch target; valid while PC_write_o=1
//   RegWrite_o    out  register file write enable (1-cycle pulse in WB)
//   ALU_op_o      out  decoded ALU operation, held until the next DECODE
//   ALUSrc_o      out  1: immediate operand
//   RegDst_o      out  1: rd destination (R-type)
//   Branch_o      out  current instruction is BEQ/BNE
//   illegal_o     out  sticky: an unknown opcode was decoded
//   fetch_err_o   out  sticky: a fetch timeout occurred
//   state_o       out  current FSM state (debug)
//   retired_o     out  retired-instruction count
//
// Fetch handshake: the request is imem_req_o. A transfer happens in any cycle
// where imem_req_o and imem_ready_i are both 1; IR_write_o marks that cycle and
// the FSM advances to DECODE on the following edge. imem_ready_i without
// imem_req_o (halted, or outside FETCH) carries no data and is ignored.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             halt_i,
   input  logic             imem_ready_i,
   input  logic [5:0]       instr_op_i,
   input  logic             zero_i,
   output logic             imem_req_o,
   output logic             IR_write_o,
   output logic             PC_write_o,
   output logic             PC_src_o,
   output logic             RegWrite_o,
   output logic [2:0]       ALU_op_o,
   output logic             ALUSrc_o,
   output logic             RegDst_o,
   output logic             Branch_o,
   output logic             illegal_o,
   output logic             fetch_err_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired_o
);

   // ---------------------------------------------------------------------------
   // State encoding (visible on state_o)
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_BRANCH = 3'd4
   } state_t;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   // ALU operation codes
   localparam logic [2:0] ALU_RTYPE = 3'd0;
   localparam logic [2:0] ALU_ADDI  = 3'd1;
   localparam logic [2:0] ALU_SLTIU = 3'd2;
   localparam logic [2:0] ALU_BEQ   = 3'd3;
   localparam logic [2:0] ALU_LUI   = 3'd4;
   localparam logic [2:0] ALU_ORI   = 3'd5;
   localparam logic [2:0] ALU_BNE   = 3'd6;

   // Wait counter only needs to reach TIMEOUT-1; it clears when it would
   // reach TIMEOUT. Keep at least one bit so TIMEOUT=0 still elaborates.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              instr_illegal;   // current instruction retires as a NOP

   // ---------------------------------------------------------------------------
   // Opcode decode (combinational, latched into the field registers in DECODE)
   // ---------------------------------------------------------------------------
   logic [2:0] dec_alu_op;
   logic       dec_alu_src;
   logic       dec_reg_dst;
   logic       dec_branch;
   logic       dec_illegal;

   always_comb begin
      dec_alu_op  = ALU_RTYPE;
      dec_alu_src = 1'b0;
      dec_reg_dst = 1'b0;
      dec_branch  = 1'b0;
      dec_illegal = 1'b0;
      case (instr_op_i)
         OP_RTYPE: begin
            dec_alu_op  = ALU_RTYPE;
            dec_reg_dst = 1'b1;
         end
         OP_ADDI: begin
            dec_alu_op  = ALU_ADDI;
            dec_alu_src = 1'b1;
         end
         OP_SLTIU: begin
            dec_alu_op  = ALU_SLTIU;
            dec_alu_src = 1'b1;
         end
         OP_BEQ: begin
            dec_alu_op  = ALU_BEQ;
            dec_branch  = 1'b1;
         end
         OP_LUI: begin
            dec_alu_op  = ALU_LUI;
            dec_alu_src = 1'b1;
         end
         OP_ORI: begin
            dec_alu_op  = ALU_ORI;
            dec_alu_src = 1'b1;
         end
         OP_BNE: begin
            dec_alu_op  = ALU_BNE;
            dec_branch  = 1'b1;
         end
         default: begin
            // Unknown opcode: all fields zero, flagged as illegal.
            dec_illegal = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Fetch handshake and branch direction
   // ---------------------------------------------------------------------------
   // The request and the IR load must track halt_i/imem_ready_i in the same
   // cycle, so they are decoded from the state register rather than latched.
   logic fetch_active;
   logic fetch_done;

   assign fetch_active = (state == S_FETCH) && !halt_i;
   assign fetch_done   = fetch_active && imem_ready_i;

   assign imem_req_o = fetch_active;
   assign IR_write_o = fetch_done;

   // zero_i is only meaningful while the ALU compares in BRANCH; BEQ takes the
   // branch on equality, BNE (the only other branch) on inequality.
   assign PC_src_o = (state == S_BRANCH) &&
                     ((ALU_op_o == ALU_BEQ) ? zero_i : ~zero_i);

   assign state_o = state;

   // ---------------------------------------------------------------------------
   // FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= S_FETCH;
         wait_cnt      <= '0;
         instr_illegal <= 1'b0;
         PC_write_o    <= 1'b0;
         RegWrite_o    <= 1'b0;
         ALU_op_o      <= ALU_RTYPE;
         ALUSrc_o      <= 1'b0;
         RegDst_o      <= 1'b0;
         Branch_o      <= 1'b0;
         illegal_o     <= 1'b0;
         fetch_err_o   <= 1'b0;
         retired_o     <= '0;
      end else begin
         // Write pulses last exactly one cycle (the WB/BRANCH cycle).
         PC_write_o <= 1'b0;
         RegWrite_o <= 1'b0;

         case (state)
            S_FETCH: begin
               if (fetch_done) begin
                  state    <= S_DECODE;
                  wait_cnt <= '0;
               end else if (fetch_active && (TIMEOUT > 0)) begin
                  // Keep requesting after a timeout; the error is sticky and
                  // the count restarts for the next window.
                  if (wait_cnt == WAIT_LAST) begin
                     fetch_err_o <= 1'b1;
                     wait_cnt    <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
            end

            S_DECODE: begin
               ALU_op_o      <= dec_alu_op;
               ALUSrc_o      <= dec_alu_src;
               RegDst_o      <= dec_reg_dst;
               Branch_o      <= dec_branch;
               instr_illegal <= dec_illegal;
               if (dec_illegal) begin
                  illegal_o <= 1'b1;
               end
               state <= S_EXEC;
            end

            S_EXEC: begin
               // Pulses for the final cycle are set here so they are registered
               // and line up with the WB/BRANCH state.
               PC_write_o <= 1'b1;
               if (Branch_o) begin
                  state <= S_BRANCH;
               end else begin
                  state      <= S_WB;
                  RegWrite_o <= !instr_illegal;
               end
            end

            S_WB, S_BRANCH: begin
               retired_o <= retired_o + CNT_W'(1);
               wait_cnt  <= '0;
               state     <= S_FETCH;
            end

            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule
